uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning CLK cycles per serial bit (min 4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of 2, >= 2).
REQ-004 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port RESETn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx  input  1  serial line (idle high, asynchronous to CLK).
REQ-007 SHALL have port rd_en  input  1  pop request for FIFO head.
REQ-008 SHALL have port rd_data  output  DATA_BITS  FIFO head, valid while empty=0 (show-ahead).
REQ-009 SHALL have port empty  output  1  FIFO holds no entries.
REQ-010 SHALL have port full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 SHALL have port count  output  clog2(FIFO_DEPTH)+1  current entry count.
REQ-012 SHALL have ports frame_err, overrun, parity_err  output  1 each  single-cycle error pulses.

Function
REQ-013 SHALL pass rx through a 2-flop synchroniser; all decoding uses the synchronised value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE -> START on synchronised rx high-to-low transition; bit counter cleared.
REQ-016 START: sample at cycle CLKS_PER_BIT/2 (integer divide); low -> DATA, high -> IDLE (glitch rejected, no pulse).
REQ-017 DATA: sample every CLKS_PER_BIT cycles after start-centre, LSB first, DATA_BITS samples, then PARITY (if enabled) else STOP.
REQ-018 STOP: one sample; high -> frame valid, -> IDLE; low -> frame_err pulse, frame discarded, -> BREAK.
REQ-019 BREAK: remain until synchronised rx high, then IDLE; no further frames or pulses while rx held low.
REQ-020 Valid frame SHALL push into FIFO in the cycle after the stop sample; empty deasserts one cycle after the push.
REQ-021 Push while full and rd_en=0 SHALL drop the frame, leave FIFO unchanged and pulse overrun.
REQ-022 Push and pop in same cycle SHALL both succeed, including when full; count unchanged.
REQ-023 rd_en while empty SHALL be ignored; no pointer or count change.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-025 Error pulses SHALL be exactly one cycle, coincident with the cycle the frame is resolved.

Reset
REQ-026 RESETn low SHALL immediately force state IDLE, pointers 0, count 0, empty=1, full=0, rd_data=0, all error pulses 0, synchroniser flops 1.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release a new start edge is needed.

Configuration
REQ-028 Macro UART_RX_PARITY_EN SHALL, when defined, enable the PARITY state: one even-parity sample after data; mismatch -> parity_err pulse, frame discarded, -> STOP handling continues.
REQ-029 Without UART_RX_PARITY_EN the PARITY state and logic SHALL be absent and parity_err tied 0.

Verification
REQ-030 Frame 0xA5 at 16 clk/bit, valid stop -> empty falls 1 cycle after stop sample, rd_data=0xA5, count=1.
REQ-031 rx held low from reset release (line break) -> exactly one frame_err pulse, FIFO stays empty, no new frame until rx returns high.
REQ-032 17 back-to-back frames 0x00..0x10, no reads, depth 16 -> full=1 after 16th, overrun pulse on 17th, head=0x00, count=16.
REQ-033 FIFO full, rd_en=1 in same cycle as 17th push -> count stays 16, no overrun, tail=0x10.
REQ-034 4-cycle low glitch on idle rx -> no state progress beyond START, no pulses, FIFO unchanged.
REQ-035 With UART_RX_PARITY_EN, frame 0x03 with parity bit 1 -> parity_err pulse, FIFO unchanged; parity bit 0 -> accepted.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (2-flop synchronised rx, mid-bit sampling) feeding a show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RESETn,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1    = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   push_q, push_d;
    logic                   ferr_d;
    logic                   rx_meta_q, rx_sync_q, rx_prev_q;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   perr_d;
`endif

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            count_q;
    logic                   do_push, do_pop;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            frame_err <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            parity_err <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (rx_prev_q && !rx_sync_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_q == LAST_BIT) state_d = StParity;
`else
                    if (bit_q == LAST_BIT) state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    state_d = StStop;
                    // Even parity: data plus parity bit must hold an even number of ones.
                    if (rx_sync_q != ^shift_q) begin
                        par_bad_d = 1'b1;
                        perr_d    = 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        push_d  = !par_bad_q;
`else
                        push_d  = 1'b1;
`endif
                    end else begin
                        state_d = StBreak;
                        ferr_d  = 1'b1;
                    end
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign do_pop  = rd_en && (count_q != '0);
    assign do_push = push_q && ((count_q != DEPTH_CNT) || do_pop);
    assign overrun = push_q && (count_q == DEPTH_CNT) && !rd_en;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // shift_q stays stable until the next frame's data bits, well after the push cycle.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr_q] <= shift_q;
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
// Honours UART_RX_PARITY_EN to add the parity bit and parity checks.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = DB + 3;
`else
    localparam int NB = DB + 2;
`endif
    localparam int STOP_CTR = (NB - 1) * CPB + CPB / 2;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [4:0] count;
    logic       frame_err, overrun, parity_err;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .rx         (rx),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int fe_exp = 0, ov_exp = 0, pe_exp = 0;
    logic [7:0] model [$];
    int push_cyc;

    // Count high cycles: a stretched pulse shows up as an extra count.
    always @(negedge CLK) begin
        if (RESETn) begin
            if (frame_err === 1'b1)  fe_cnt++;
            if (overrun === 1'b1)    ov_cnt++;
            if (parity_err === 1'b1) pe_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, " count"}, 32'(count), 32'(model.size()));
        check_val({tag, " empty"}, 32'(empty), 32'(model.size() == 0));
        check_val({tag, " full"}, 32'(full), 32'(model.size() == DEPTH));
        check_val({tag, " frame_err pulses"}, 32'(fe_cnt), 32'(fe_exp));
        check_val({tag, " overrun pulses"}, 32'(ov_cnt), 32'(ov_exp));
        check_val({tag, " parity_err pulses"}, 32'(pe_cnt), 32'(pe_exp));
        if (model.size() > 0) check_val({tag, " head"}, 32'(rd_data), 32'(model[0]));
    endtask

    task automatic pop_check(input string tag);
        check_val({tag, " empty"}, 32'(empty), 32'(model.size() == 0));
        if (model.size() > 0) check_val({tag, " data"}, 32'(rd_data), 32'(model[0]));
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (model.size() > 0) void'(model.pop_front());
    endtask

    // Drives one frame starting just after a rising edge; rd_en is raised for the one
    // cycle following edge number rd_at (counted from the start-bit fall).
    task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par,
                              input int rd_at, output int fall_at);
        logic [11:0] bits;
        logic        pe;
        int          cyc;
        bits      = '0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^d) ^ bad_par;
        bits[10] = ~bad_stop;
`else
        bits[9]  = ~bad_stop;
`endif
        cyc     = 0;
        pe      = empty;
        fall_at = -1;
        for (int i = 0; i < NB; i++) begin
            rx = bits[i];
            for (int k = 0; k < CPB; k++) begin
                tick(1);
                cyc++;
                rd_en = (cyc == rd_at);
                if (pe && !empty && fall_at < 0) fall_at = cyc;
                pe = empty;
            end
        end
        rd_en = 1'b0;
        rx    = 1'b1;
        if (bad_stop) tick(CPB);
    endtask

    task automatic model_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par,
                               input bit popped);
        if (bad_par) pe_exp++;
        if (bad_stop) fe_exp++;
        if (bad_stop || bad_par) return;
        if (popped && model.size() > 0) void'(model.pop_front());
        if (model.size() < DEPTH) model.push_back(d);
        else ov_exp++;
    endtask

    initial begin
        int         fall;
        logic [7:0] d;
        bit         bs, bp;

        rx     = 1'b1;
        rd_en  = 1'b0;
        RESETn = 1'b0;
        tick(3);
        check_val("reset empty", 32'(empty), 32'd1);
        check_val("reset full", 32'(full), 32'd0);
        check_val("reset count", 32'(count), 32'd0);
        check_val("reset rd_data", 32'(rd_data), 32'd0);
        check_val("reset pulses", 32'({frame_err, overrun, parity_err}), 32'd0);
        RESETn = 1'b1;
        tick(5);

        // Single frame 0xA5: empty must fall just after the stop-bit centre.
        send_frame(8'hA5, 1'b0, 1'b0, -1, fall);
        check_val("a5 empty fall window", 32'(fall >= STOP_CTR && fall <= STOP_CTR + 6), 32'd1);
        push_cyc = (fall > 0) ? fall - 1 : STOP_CTR + 2;
        model_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check_val("a5 rd_data", 32'(rd_data), 32'hA5);
        check_all("a5");
        pop_check("a5 pop");

        // Random back-to-back frames, occasional framing errors, random reads.
        for (int i = 0; i < 24; i++) begin
            d  = 8'($urandom);
            bs = ($urandom_range(0, 5) == 0);
            bp = 1'b0;
`ifdef UART_RX_PARITY_EN
            bp = !bs && ($urandom_range(0, 5) == 0);
`endif
            send_frame(d, bs, bp, -1, fall);
            model_frame(d, bs, bp, 1'b0);
            check_all("rand frame");
            for (int r = $urandom_range(0, 2); r > 0; r--) pop_check("rand pop");
        end
        while (model.size() > 0) pop_check("drain");
        pop_check("pop on empty");
        check_all("pop on empty");

        // Short low glitch on idle line.
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(200);
        check_all("glitch");

        // Overflow: 17 frames, no reads.
        for (int v = 0; v <= 16; v++) begin
            send_frame(8'(v), 1'b0, 1'b0, -1, fall);
            model_frame(8'(v), 1'b0, 1'b0, 1'b0);
            if (v == 15) check_val("full after 16", 32'(full), 32'd1);
        end
        check_all("overrun");
        check_val("overrun head", 32'(rd_data), 32'h00);
        while (model.size() > 0) pop_check("ovr drain");

        // Full FIFO with a pop in the same cycle as the 17th push.
        for (int v = 0; v < 16; v++) begin
            send_frame(8'(v), 1'b0, 1'b0, -1, fall);
            model_frame(8'(v), 1'b0, 1'b0, 1'b0);
        end
        send_frame(8'h10, 1'b0, 1'b0, push_cyc, fall);
        model_frame(8'h10, 1'b0, 1'b0, 1'b1);
        check_all("push+pop full");
        while (model.size() > 0) pop_check("pp drain");

        // Asynchronous reset in the middle of a frame with data queued.
        send_frame(8'h11, 1'b0, 1'b0, -1, fall);
        model_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, -1, fall);
        model_frame(8'h22, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(20);
        RESETn = 1'b0;
        #2;
        check_val("midframe reset count", 32'(count), 32'd0);
        check_val("midframe reset empty", 32'(empty), 32'd1);
        check_val("midframe reset rd_data", 32'(rd_data), 32'd0);
        model.delete();
        tick(3);
        RESETn = 1'b1;
        tick(300);
        check_all("after midframe reset");

        // Line held low from reset release: one framing error, then silence.
        RESETn = 1'b0;
        rx     = 1'b0;
        tick(2);
        RESETn = 1'b1;
        tick(400);
        fe_exp++;
        check_all("line break");
        rx = 1'b1;
        tick(20);
        send_frame(8'h3C, 1'b0, 1'b0, -1, fall);
        model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_all("after break");
        pop_check("after break pop");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b0, 1'b1, -1, fall);
        model_frame(8'h03, 1'b0, 1'b1, 1'b0);
        check_all("parity bad");
        send_frame(8'h03, 1'b0, 1'b0, -1, fall);
        model_frame(8'h03, 1'b0, 1'b0, 1'b0);
        check_all("parity good");
        pop_check("parity pop");
`endif
        check_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
